ex: RTL and testbench

//  Execute stage of the 5-stage RV32IM core; consumes the id_ex pipeline register outputs.

---
 rtl/ex_pkg.sv | 81 ++++++++
 rtl/ex_div.sv | 140 ++++++++++++++
 rtl/ex.sv | 186 ++++++++++++++++++
 tb/tb_ex.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants, types and helpers for the execute stage.
//   - RV32IM opcode / funct3 / funct7 encodings used by the execute stage
//   - reset level, bus widths, zero word
//   - divider op and FSM state enums
//   - alu_calc: the RV32I integer ALU shared by the OP and OP-IMM paths
package ex_pkg;

  localparam logic        RST_ENABLE  = 1'b1;
  localparam int          REG_W       = 32;
  localparam int          REG_ADDR_W  = 5;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  // Major opcodes
  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_LUI      = 7'b0110111;
  localparam logic [6:0] INST_AUIPC    = 7'b0010111;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;

  // funct7 values for the R/M group
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Divide-family op; encoding equals funct3[1:0] of DIV/DIVU/REM/REMU.
  // bit0 = unsigned, bit1 = remainder.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // alt selects SUB for F3_ADD and arithmetic shift for F3_SR.
  function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic [4:0]  sh;
    sh  = b[4:0];
    res = ZERO_WORD;
    case (f3)
      F3_ADD:  res = alt ? (a - b) : (a + b);
      F3_SLL:  res = a << sh;
      F3_SLT:  res = {31'd0, ($signed(a) < $signed(b))};
      F3_SLTU: res = {31'd0, (a < b)};
      F3_XOR:  res = a ^ b;
      F3_SR:   res = alt ? 32'($signed(a) >>> sh) : (a >> sh);
      F3_OR:   res = a | b;
      F3_AND:  res = a & b;
      default: res = ZERO_WORD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           divide-family instruction present this cycle (used only in IDLE)
//   op              DIV/DIVU/REM/REMU
//   dividend        rs1 value
//   divisor         rs2 value
//   rd              destination register of the divide
//   busy            start cycle (while IDLE) or iterating; front of the pipe must hold
//   ready           result valid this cycle (DONE state)
//   result          sign-corrected quotient or remainder
//   result_rd       latched destination register
// Works on magnitudes; signs are reapplied at the output so the signed overflow
// case 0x80000000 / -1 needs no special handling.
module ex_div
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  div_op_e               op,
  input  logic [REG_W-1:0]      dividend,
  input  logic [REG_W-1:0]      divisor,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  busy,
  output logic                  ready,
  output logic [REG_W-1:0]      result,
  output logic [REG_ADDR_W-1:0] result_rd
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_e            state_reg, state_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [REG_W-1:0]      quo_reg, quo_next;     // dividend shifts out, quotient shifts in
  logic [REG_W-1:0]      rem_reg, rem_next;     // partial remainder
  logic [REG_W-1:0]      dsor_reg, dsor_next;   // divisor magnitude
  div_op_e               op_reg, op_next;
  logic                  neg_q_reg, neg_q_next;
  logic                  neg_r_reg, neg_r_next;
  logic [REG_ADDR_W-1:0] rd_reg, rd_next;

  logic                  signed_op;
  logic                  a_neg, b_neg;
  logic [REG_W-1:0]      a_mag, b_mag;
  logic [REG_W:0]        partial;

  assign signed_op = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign a_neg     = signed_op & dividend[REG_W-1];
  assign b_neg     = signed_op & divisor[REG_W-1];
  assign a_mag     = a_neg ? (-dividend) : dividend;
  assign b_mag     = b_neg ? (-divisor)  : divisor;
  assign partial   = {rem_reg, quo_reg[REG_W-1]};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg <= DIV_IDLE;
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsor_reg  <= '0;
      op_reg    <= DIV_OP_DIV;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dsor_reg  <= dsor_next;
      op_reg    <= op_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      rd_reg    <= rd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dsor_next  = dsor_reg;
    op_next    = op_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    rd_next    = rd_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (start) begin
          op_next = op;
          rd_next = rd;
          if (divisor == ZERO_WORD) begin
            // Architectural div-by-zero results, no sign correction applied.
            quo_next   = '1;
            rem_next   = dividend;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DIV_DONE;
          end else begin
            quo_next   = a_mag;
            rem_next   = '0;
            dsor_next  = b_mag;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            count_next = '0;
            state_next = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (partial >= {1'b0, dsor_reg}) begin
          rem_next = REG_W'(partial - {1'b0, dsor_reg});
          quo_next = {quo_reg[REG_W-2:0], 1'b1};
        end else begin
          rem_next = partial[REG_W-1:0];
          quo_next = {quo_reg[REG_W-2:0], 1'b0};
        end
        count_next = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(DIV_CYCLES - 1)) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // busy is combinational in the start cycle so the pipe holds immediately.
  assign busy      = (rst != RST_ENABLE) &&
                     (((state_reg == DIV_IDLE) && start) || (state_reg == DIV_CALC));
  assign ready     = (rst != RST_ENABLE) && (state_reg == DIV_DONE);
  assign result    = op_reg[1] ? (neg_r_reg ? (-rem_reg) : rem_reg)
                               : (neg_q_reg ? (-quo_reg) : quo_reg);
  assign result_rd = rd_reg;

endmodule

// File: rtl/ex.sv
// ex: execute stage of the 5-stage RV32IM core.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pc_i, inst_i          instruction address and word (all-zero word = bubble)
//   reg1_i, reg2_i        rs1 / rs2 values
//   imm_i                 sign-extended immediate
//   reg_waddr_i, reg_we_i rd and its write request from decode
//   reg_wdata_o/_waddr_o/_we_o  writeback
//   jump_flag_o, jump_addr_o    taken branch/jump and its target
//   hold_req_o            divider busy; the front of the pipe holds
// Single-cycle ops are purely combinational from the inputs. Divides go to ex_div;
// while it is busy or delivering, the incoming word is ignored (decode feeds bubbles).
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      pc_i,
  input  logic [REG_W-1:0]      inst_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_W-1:0]      imm_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  output logic [REG_W-1:0]      reg_wdata_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic                  reg_we_o,
  output logic                  jump_flag_o,
  output logic [REG_W-1:0]      jump_addr_o,
  output logic                  hold_req_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_inst_bits;

  assign opcode           = inst_i[6:0];
  assign funct3           = inst_i[14:12];
  assign funct7           = inst_i[31:25];
  // Register fields are already resolved by decode into reg*_i / reg_waddr_i.
  assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

  // ---------------- divider ----------------
  logic                  is_div;
  logic                  div_busy, div_ready;
  logic [REG_W-1:0]      div_result;
  logic [REG_ADDR_W-1:0] div_rd;

  assign is_div = (opcode == INST_TYPE_R_M) && (funct7 == F7_M) && funct3[2];

  ex_div #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .op        (div_op_e'(funct3[1:0])),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .rd        (reg_waddr_i),
    .busy      (div_busy),
    .ready     (div_ready),
    .result    (div_result),
    .result_rd (div_rd)
  );

  // ---------------- multiplier ----------------
  // One 33x33 signed multiply covers all four forms via per-operand extension.
  logic               mul_a_signed, mul_b_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_prod;
  logic [REG_W-1:0]   mul_result;

  assign mul_a_signed = (funct3[1:0] != 2'b11);                        // MUL, MULH, MULHSU
  assign mul_b_signed = (funct3[1:0] == 2'b00) || (funct3[1:0] == 2'b01); // MUL, MULH
  assign mul_a        = {mul_a_signed & reg1_i[31], reg1_i};
  assign mul_b        = {mul_b_signed & reg2_i[31], reg2_i};
  assign mul_prod     = $signed({{31{mul_a[32]}}, mul_a}) * $signed({{31{mul_b[32]}}, mul_b});
  assign mul_result   = (funct3[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

  // ---------------- branch compare ----------------
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (reg1_i == reg2_i);
      F3_BNE:  br_taken = (reg1_i != reg2_i);
      F3_BLT:  br_taken = ($signed(reg1_i) <  $signed(reg2_i));
      F3_BGE:  br_taken = ($signed(reg1_i) >= $signed(reg2_i));
      F3_BLTU: br_taken = (reg1_i <  reg2_i);
      F3_BGEU: br_taken = (reg1_i >= reg2_i);
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic             alu_supported;
  logic [REG_W-1:0] alu_wdata;
  logic             alu_jump;
  logic [REG_W-1:0] alu_jaddr;
  logic [REG_W-1:0] link_addr;

  assign link_addr = pc_i + 32'd4;

  always_comb begin
    alu_supported = 1'b0;
    alu_wdata     = ZERO_WORD;
    alu_jump      = 1'b0;
    alu_jaddr     = ZERO_WORD;
    case (opcode)
      INST_TYPE_I: begin
        alu_supported = 1'b1;
        // inst_i[30] is immediate data except for SRLI/SRAI.
        alu_wdata = alu_calc(funct3, (funct3 == F3_SR) && inst_i[30], reg1_i, imm_i);
      end
      INST_TYPE_R_M: begin
        if (funct7 == F7_M) begin
          if (!funct3[2]) begin
            alu_supported = 1'b1;
            alu_wdata     = mul_result;
          end
        end else if ((funct7 == F7_BASE) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))) begin
          alu_supported = 1'b1;
          alu_wdata     = alu_calc(funct3, funct7[5], reg1_i, reg2_i);
        end
      end
      INST_LUI: begin
        alu_supported = 1'b1;
        alu_wdata     = imm_i;
      end
      INST_AUIPC: begin
        alu_supported = 1'b1;
        alu_wdata     = pc_i + imm_i;
      end
      INST_JAL: begin
        alu_supported = 1'b1;
        alu_wdata     = link_addr;
        alu_jump      = 1'b1;
        alu_jaddr     = pc_i + imm_i;
      end
      INST_JALR: begin
        alu_supported = 1'b1;
        alu_wdata     = link_addr;
        alu_jump      = 1'b1;
        alu_jaddr     = (reg1_i + imm_i) & ~32'd1;
      end
      INST_TYPE_B: begin
        alu_supported = 1'b1;
        alu_jump      = br_taken;
        alu_jaddr     = br_taken ? (pc_i + imm_i) : ZERO_WORD;
      end
      default: alu_supported = 1'b0;
    endcase
  end

  // ---------------- output mux ----------------
  always_comb begin
    reg_wdata_o = ZERO_WORD;
    reg_waddr_o = '0;
    reg_we_o    = 1'b0;
    jump_flag_o = 1'b0;
    jump_addr_o = ZERO_WORD;
    hold_req_o  = 1'b0;
    if (rst == RST_ENABLE) begin
      // all outputs stay at zero
    end else if (div_ready) begin
      reg_we_o    = 1'b1;
      reg_waddr_o = div_rd;
      reg_wdata_o = div_result;
    end else if (div_busy) begin
      hold_req_o = 1'b1;
    end else if (alu_supported) begin
      reg_we_o    = reg_we_i;
      reg_waddr_o = reg_waddr_i;
      reg_wdata_o = alu_wdata;
      jump_flag_o = alu_jump;
      jump_addr_o = alu_jaddr;
    end
  end

endmodule

// File: tb/tb_ex.sv
module tb_ex;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0, inst_i = '0, reg1_i = '0, reg2_i = '0, imm_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_o, jump_addr_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o, jump_flag_o, hold_req_o;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [31:0] wd;
  logic        dwe, leak;
  logic [4:0]  wa;

  always #5 clk = ~clk;

  ex #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .reg1_i(reg1_i),
    .reg2_i(reg2_i), .imm_i(imm_i), .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
    .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_req_o(hold_req_o)
  );

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] opc, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one single-cycle instruction after a posedge; return at the negedge.
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                       input logic we);
    @(posedge clk); #1;
    inst_i = inst; pc_i = pc; reg1_i = r1; reg2_i = r2; imm_i = imm;
    reg_waddr_i = rd; reg_we_i = we;
    @(negedge clk);
    $display("step inst=%08h r1=%08h r2=%08h imm=%08h -> we=%0b wd=%08h wa=%0d jf=%0b ja=%08h hold=%0b",
             inst, r1, r2, imm, reg_we_o, reg_wdata_o, reg_waddr_o, jump_flag_o, jump_addr_o, hold_req_o);
  endtask

  // Issue a divide, feed bubbles (plus one illegal non-bubble at cycle inj), and
  // return the cycle index of the first hold_req=0 cycle with the outputs seen there.
  task automatic div_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int inj, output int lat_o,
                         output logic [31:0] wd_o, output logic we_o, output logic [4:0] wa_o,
                         output logic leak_o);
    lat_o = -1; wd_o = '0; we_o = 1'b0; wa_o = '0; leak_o = 1'b0;
    @(posedge clk); #1;
    inst_i = mk(7'h01, f3, OP_R, rd); reg1_i = a; reg2_i = b;
    reg_waddr_i = rd; reg_we_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == inj) begin
          inst_i = mk(7'h01, 3'b100, OP_R, 5'd9); reg1_i = 32'h1234; reg_waddr_i = 5'd9;
        end else begin
          inst_i = '0;
        end
      end
      @(negedge clk);
      if (!hold_req_o) begin
        lat_o = n; wd_o = reg_wdata_o; we_o = reg_we_o; wa_o = reg_waddr_o;
        break;
      end
      if (reg_we_o || jump_flag_o) leak_o = 1'b1;
    end
    $display("div f3=%0d a=%08h b=%08h rd=%0d -> lat=%0d we=%0b wd=%08h wa=%0d",
             f3, a, b, rd, lat_o, we_o, wd_o, wa_o);
  endtask

  initial begin
    // ---- reset: all outputs zero ----
    drive(mk(7'h7F, 3'b000, OP_IMM, 5'd3), 32'h0, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd3, 1'b1);
    chk("rst_we", {31'd0, reg_we_o}, 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    drive(mk(7'h00, 3'b000, OP_JAL, 5'd1), 32'h1000, 32'd0, 32'd0, 32'h800, 5'd1, 1'b1);
    chk("rst_jf", {31'd0, jump_flag_o}, 32'd0);
    chk("rst_ja", jump_addr_o, 32'd0);
    drive(mk(7'h01, 3'b100, OP_R, 5'd2), 32'h0, 32'd7, 32'd2, 32'd0, 5'd2, 1'b1);
    chk("rst_hold", {31'd0, hold_req_o}, 32'd0);
    inst_i = '0;
    rst = 1'b0;

    // ---- single-cycle ops ----
    drive(mk(7'h7F, 3'b000, OP_IMM, 5'd3), 32'h0, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd3, 1'b1);
    chk("addi_wd", reg_wdata_o, 32'hFFFF_FFFE);
    chk("addi_we", {31'd0, reg_we_o}, 32'd1);
    chk("addi_wa", {27'd0, reg_waddr_o}, 32'd3);
    chk("addi_jf", {31'd0, jump_flag_o}, 32'd0);
    drive(mk(7'h20, 3'b000, OP_R, 5'd4), 32'h0, 32'd5, 32'd7, 32'd0, 5'd4, 1'b1);
    chk("sub", reg_wdata_o, 32'hFFFF_FFFE);
    drive(mk(7'h20, 3'b101, OP_R, 5'd5), 32'h0, 32'h8000_0000, 32'd4, 32'd0, 5'd5, 1'b1);
    chk("sra", reg_wdata_o, 32'hF800_0000);
    drive(mk(7'h20, 3'b101, OP_IMM, 5'd5), 32'h0, 32'h8000_0000, 32'd0, 32'h404, 5'd5, 1'b1);
    chk("srai", reg_wdata_o, 32'hF800_0000);
    drive(mk(7'h00, 3'b101, OP_IMM, 5'd5), 32'h0, 32'h8000_0000, 32'd0, 32'd4, 5'd5, 1'b1);
    chk("srli", reg_wdata_o, 32'h0800_0000);
    drive(mk(7'h00, 3'b001, OP_R, 5'd5), 32'h0, 32'h0000_0003, 32'h0000_0024, 32'd0, 5'd5, 1'b1);
    chk("sll_shamt5", reg_wdata_o, 32'h0000_0030);
    drive(mk(7'h00, 3'b010, OP_R, 5'd6), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 1'b1);
    chk("slt", reg_wdata_o, 32'd1);
    drive(mk(7'h00, 3'b011, OP_R, 5'd6), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 1'b1);
    chk("sltu", reg_wdata_o, 32'd0);
    drive(mk(7'h01, 3'b000, OP_R, 5'd8), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8, 1'b1);
    chk("mul", reg_wdata_o, 32'd1);
    drive(mk(7'h01, 3'b001, OP_R, 5'd8), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8, 1'b1);
    chk("mulh", reg_wdata_o, 32'd0);
    drive(mk(7'h01, 3'b010, OP_R, 5'd8), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8, 1'b1);
    chk("mulhsu", reg_wdata_o, 32'hFFFF_FFFF);
    drive(mk(7'h01, 3'b011, OP_R, 5'd8), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8, 1'b1);
    chk("mulhu", reg_wdata_o, 32'hFFFF_FFFE);
    drive(mk(7'h55, 3'b000, OP_LUI, 5'd9), 32'h0, 32'd0, 32'd0, 32'hABCD_E000, 5'd9, 1'b1);
    chk("lui", reg_wdata_o, 32'hABCD_E000);
    drive(mk(7'h09, 3'b001, OP_AUI, 5'd9), 32'h1000, 32'd0, 32'd0, 32'h1234_5000, 5'd9, 1'b1);
    chk("auipc", reg_wdata_o, 32'h1234_6000);

    // ---- branches and jumps ----
    drive(mk(7'h01, 3'b000, OP_BR, 5'd0), 32'h100, 32'h55, 32'h55, 32'h20, 5'd0, 1'b0);
    chk("beq_t_jf", {31'd0, jump_flag_o}, 32'd1);
    chk("beq_t_ja", jump_addr_o, 32'h120);
    chk("beq_t_we", {31'd0, reg_we_o}, 32'd0);
    drive(mk(7'h01, 3'b000, OP_BR, 5'd0), 32'h100, 32'h55, 32'h56, 32'h20, 5'd0, 1'b0);
    chk("beq_nt_jf", {31'd0, jump_flag_o}, 32'd0);
    chk("beq_nt_ja", jump_addr_o, 32'd0);
    drive(mk(7'h7F, 3'b100, OP_BR, 5'd0), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 5'd0, 1'b0);
    chk("blt_ja", jump_addr_o, 32'h1F8);
    drive(mk(7'h7F, 3'b110, OP_BR, 5'd0), 32'h200, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 5'd0, 1'b0);
    chk("bltu_jf", {31'd0, jump_flag_o}, 32'd0);
    drive(mk(7'h00, 3'b000, OP_JAL, 5'd1), 32'h1000, 32'd0, 32'd0, 32'h800, 5'd1, 1'b1);
    chk("jal_ja", jump_addr_o, 32'h1800);
    chk("jal_wd", reg_wdata_o, 32'h1004);
    drive(mk(7'h00, 3'b000, OP_JALR, 5'd1), 32'h40, 32'h203, 32'd0, 32'd4, 5'd1, 1'b1);
    chk("jalr_ja", jump_addr_o, 32'h206);
    chk("jalr_wd", reg_wdata_o, 32'h44);
    chk("jalr_jf", {31'd0, jump_flag_o}, 32'd1);
    drive(mk(7'h00, 3'b010, OP_LOAD, 5'd7), 32'h0, 32'h100, 32'd0, 32'd4, 5'd7, 1'b1);
    chk("load_we", {31'd0, reg_we_o}, 32'd0);
    drive(32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("bubble_hold", {31'd0, hold_req_o}, 32'd0);

    // ---- divider ----
    div_run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 5, lat, wd, dwe, wa, leak);
    chk("div_lat", 32'(lat), 32'd33);
    chk("div_wd", wd, 32'hFFFF_FFFD);
    chk("div_we", {31'd0, dwe}, 32'd1);
    chk("div_wa", {27'd0, wa}, 32'd7);
    chk("div_noleak", {31'd0, leak}, 32'd0);
    div_run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, lat, wd, dwe, wa, leak);
    chk("rem_wd", wd, 32'hFFFF_FFFF);
    div_run(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd11, 0, lat, wd, dwe, wa, leak);
    chk("div_negdsor", wd, 32'hFFFF_FFF2);
    div_run(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd11, 0, lat, wd, dwe, wa, leak);
    chk("rem_negdsor", wd, 32'd2);
    div_run(3'b101, 32'h0000_1234, 32'd0, 5'd12, 0, lat, wd, dwe, wa, leak);
    chk("divu0_lat", 32'(lat), 32'd1);
    chk("divu0_wd", wd, 32'hFFFF_FFFF);
    chk("divu0_we", {31'd0, dwe}, 32'd1);
    div_run(3'b111, 32'd9, 32'd0, 5'd12, 0, lat, wd, dwe, wa, leak);
    chk("remu0_wd", wd, 32'd9);
    div_run(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd12, 0, lat, wd, dwe, wa, leak);
    chk("rem0_neg_wd", wd, 32'hFFFF_FFFB);
    div_run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, lat, wd, dwe, wa, leak);
    chk("div_ovf", wd, 32'h8000_0000);
    div_run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, lat, wd, dwe, wa, leak);
    chk("rem_ovf", wd, 32'd0);

    // ---- reset in the middle of a divide ----
    @(posedge clk); #1;
    inst_i = mk(7'h01, 3'b101, OP_R, 5'd5); reg1_i = 32'd100; reg2_i = 32'd7;
    reg_waddr_i = 5'd5; reg_we_i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      inst_i = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    $display("rst mid-calc -> hold=%0b we=%0b wd=%08h", hold_req_o, reg_we_o, reg_wdata_o);
    chk("midrst_hold", {31'd0, hold_req_o}, 32'd0);
    chk("midrst_we", {31'd0, reg_we_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    $display("after rst -> hold=%0b we=%0b wd=%08h", hold_req_o, reg_we_o, reg_wdata_o);
    chk("postrst_hold", {31'd0, hold_req_o}, 32'd0);
    chk("postrst_we", {31'd0, reg_we_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_idle", {31'd0, hold_req_o | reg_we_o}, 32'd0);
    div_run(3'b101, 32'd100, 32'd7, 5'd5, 0, lat, wd, dwe, wa, leak);
    chk("divu_lat", 32'(lat), 32'd33);
    chk("divu_wd", wd, 32'd14);
    chk("divu_wa", {27'd0, wa}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
